// File: rtl/bsearch_engine.sv
// Binary-search controller over a sorted external synchronous RAM.
// Reports found/loc/probes and supports ascending or descending order and any read latency.
module bsearch_engine #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              descending,
  input  logic [DATA_W-1:0] target,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] loc,
  output logic [ADDR_W:0]   probes
);

  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state, next_state;
  logic [ADDR_W-1:0] lo, hi, mid;
  logic [ADDR_W:0]   mid_sum;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] tgt;
  logic              desc;
  logic              hit, go_lower, exhausted;

  // Midpoint and compare decision; mem_addr holds the current probe address
  always_comb begin
    mid_sum   = {1'b0, lo} + {1'b0, hi};
    mid       = ADDR_W'(mid_sum >> 1);
    hit       = (mem_rdata == tgt);
    go_lower  = desc ? (tgt > mem_rdata) : (tgt < mem_rdata);
    exhausted = go_lower ? (mem_addr == lo) : (mem_addr == hi);
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_SETUP;
      S_SETUP:   next_state = S_WAIT;
      S_WAIT:    if (cnt == '0) next_state = S_COMPARE;
      S_COMPARE: next_state = (hit || exhausted) ? S_DONE : S_SETUP;
      S_DONE:    if (!start) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // State register, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      loc      <= '0;
      probes   <= '0;
      lo       <= '0;
      hi       <= ADDR_MAX;
      cnt      <= '0;
      tgt      <= '0;
      desc     <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == S_SETUP) || (next_state == S_WAIT) ||
               (next_state == S_COMPARE);
      done  <= (next_state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            tgt    <= target;
            desc   <= descending;
            probes <= '0;
            found  <= 1'b0;
            loc    <= '0;
            lo     <= '0;
            hi     <= ADDR_MAX;
          end
        end
        S_SETUP: begin
          mem_addr <= mid;
          cnt      <= CNT_W'(READ_LAT - 1);
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        S_COMPARE: begin
          probes <= probes + (ADDR_W + 1)'(1);
          if (hit) begin
            found <= 1'b1;
            loc   <= mem_addr;
          end else if (!exhausted) begin
            if (go_lower) hi <= mem_addr - ADDR_W'(1);
            else          lo <= mem_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bsearch_engine.sv
// Directed bench for bsearch_engine: READ_LAT=1 and READ_LAT=3 instances share one RAM image.
module tb_bsearch_engine;

  logic       clk = 1'b0;
  logic       reset, start, descending;
  logic [7:0] target;
  logic [7:0] ram [32];

  logic [4:0] addr1, loc1, addr3, loc3;
  logic [7:0] rdata1, rdata3;
  logic       busy1, done1, found1, busy3, done3, found3;
  logic [5:0] probes1, probes3;
  logic [4:0] a3_d1, a3_d2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsearch_engine #(.DATA_W(8), .ADDR_W(5), .READ_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .descending(descending),
    .target(target), .mem_addr(addr1), .mem_rdata(rdata1), .busy(busy1),
    .done(done1), .found(found1), .loc(loc1), .probes(probes1));

  bsearch_engine #(.DATA_W(8), .ADDR_W(5), .READ_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .descending(descending),
    .target(target), .mem_addr(addr3), .mem_rdata(rdata3), .busy(busy3),
    .done(done3), .found(found3), .loc(loc3), .probes(probes3));

  // RAM models: 1-cycle and 3-cycle read latency from address change
  always_ff @(posedge clk) begin
    rdata1 <= ram[addr1];
    a3_d1  <= addr3;
    a3_d2  <= a3_d1;
    rdata3 <= ram[a3_d2];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit desc_data);
    for (int i = 0; i < 32; i++)
      ram[i] = desc_data ? 8'(255 - 3 * i) : 8'(2 * i);
  endtask

  // Raise start and wait (bounded) until both instances report done
  task automatic run_search(input logic [7:0] t, input logic d, input string tag);
    int n;
    target = t;
    descending = d;
    start = 1'b1;
    n = 0;
    while (!(done1 && done3) && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done_timeout"}, 32'(done1 && done3), 32'd1);
  endtask

  task automatic release_start();
    start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    descending = 1'b0;
    target = '0;
    fill(1'b0);
    tick();
    tick();
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_found", 32'(found1), 0);
    check("rst_loc", 32'(loc1), 0);
    check("rst_probes", 32'(probes1), 0);
    check("rst_addr", 32'(addr1), 0);
    check("rst_done3", 32'(done3), 0);
    reset = 1'b0;
    tick();

    // Exact latency for a single-probe hit: 3 cycles (LAT1), 5 cycles (LAT3)
    target = 8'd30;
    start = 1'b1;
    tick();
    check("t30_busy_e0", 32'(busy1), 1);
    tick();
    tick();
    check("t30_done_e2", 32'(done1), 0);
    tick();
    check("t30_done_e3", 32'(done1), 1);
    check("t30_found", 32'(found1), 1);
    check("t30_loc", 32'(loc1), 15);
    check("t30_probes", 32'(probes1), 1);
    check("t30_busy_done", 32'(busy1), 0);
    check("lat3_done_e3", 32'(done3), 0);
    tick();
    check("lat3_done_e4", 32'(done3), 0);
    tick();
    check("lat3_done_e5", 32'(done3), 1);
    check("lat3_loc", 32'(loc3), 15);
    check("lat3_probes", 32'(probes3), 1);
    tick();
    tick();
    tick();
    check("hold_done", 32'(done1), 1);
    check("hold_probes", 32'(probes1), 1);
    start = 1'b0;
    tick();
    check("rel_done", 32'(done1), 0);
    check("rel_found", 32'(found1), 1);
    check("rel_loc", 32'(loc1), 15);
    check("rel_probes", 32'(probes1), 1);
    tick();

    run_search(8'd0, 1'b0, "t0");
    check("t0_found", 32'(found1), 1);
    check("t0_loc", 32'(loc1), 0);
    check("t0_probes", 32'(probes1), 5);
    check("t0_loc3", 32'(loc3), 0);
    release_start();

    run_search(8'd62, 1'b0, "t62");
    check("t62_found", 32'(found1), 1);
    check("t62_loc", 32'(loc1), 31);
    check("t62_probes", 32'(probes1), 6);
    check("t62_loc3", 32'(loc3), 31);
    release_start();

    run_search(8'd31, 1'b0, "t31");
    check("t31_found", 32'(found1), 0);
    check("t31_loc", 32'(loc1), 0);
    check("t31_probes", 32'(probes1), 5);
    check("t31_last_addr", 32'(addr1), 16);
    release_start();

    run_search(8'd255, 1'b0, "t255");
    check("t255_found", 32'(found1), 0);
    check("t255_loc", 32'(loc1), 0);
    check("t255_probes", 32'(probes1), 6);
    check("t255_last_addr", 32'(addr1), 31);
    release_start();

    fill(1'b1);
    run_search(8'd195, 1'b1, "d195");
    check("d195_found", 32'(found1), 1);
    check("d195_loc", 32'(loc1), 20);
    check("d195_probes", 32'(probes1), 5);
    check("d195_loc3", 32'(loc3), 20);
    release_start();

    // Wrong order: ascending search over descending data must still terminate
    run_search(8'd195, 1'b0, "a195");
    check("a195_found", 32'(found1), 0);
    check("a195_probes", 32'(probes1), 5);
    check("a195_bound", 32'(probes1 <= 6'd6), 1);
    release_start();

    // Reset during WAIT of the third probe, then restart with start still high
    fill(1'b0);
    target = 8'd62;
    descending = 1'b0;
    start = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy", 32'(busy1), 1);
    check("mid_probes", 32'(probes1), 2);
    reset = 1'b1;
    tick();
    check("mrst_busy", 32'(busy1), 0);
    check("mrst_done", 32'(done1), 0);
    check("mrst_addr", 32'(addr1), 0);
    check("mrst_probes", 32'(probes1), 0);
    check("mrst_found", 32'(found1), 0);
    reset = 1'b0;
    run_search(8'd62, 1'b0, "rerun");
    check("rerun_found", 32'(found1), 1);
    check("rerun_loc", 32'(loc1), 31);
    check("rerun_probes", 32'(probes1), 6);
    release_start();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
